mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Parameters
REQ-001 SHALL: XLEN, default 64, datapath/address width; legal values 32, 64.
REQ-002 SHALL: TIMEOUT, default 255, max cycles waiting for mem_ready; 0 disables the timeout.

Interface
REQ-003 SHALL: clock  in  1  sole clock, rising edge.
REQ-004 SHALL: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL: in_valid  in  1  upstream instruction present this cycle.
REQ-006 SHALL: in_ready  out  1  unit accepts upstream this cycle.
REQ-007 SHALL: me_mem_rena / me_mem_wena  in  1 each  load / store request.
REQ-008 SHALL: me_size  in  2  access size: 0=B, 1=H, 2=W, 3=D.
REQ-009 SHALL: me_unsigned  in  1  zero-extend load when 1, sign-extend when 0.
REQ-010 SHALL: me_alu_result  in  XLEN  effective address, or pass-through result.
REQ-011 SHALL: me_new_rs2_data  in  XLEN  store data, right-aligned.
REQ-012 SHALL: mem_valid out 1; mem_ready in 1; mem_req out 1 (1=write); mem_addr out XLEN; mem_wdata out XLEN; mem_wstrb out XLEN/8; mem_size out 2; mem_rdata in XLEN (naturally aligned word); mem_resp in 2 (0=OKAY).
REQ-013 SHALL: wb_valid out 1; wb_data out XLEN; wb_fault out 1 (misaligned, bus error or timeout); stall_req out 1.

Function
REQ-014 SHALL: FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE).
REQ-015 SHALL: IDLE, in_valid, no mem op -> DONE with wb_data=me_alu_result, wb_fault=0; 1-cycle latency.
REQ-016 SHALL: misaligned = address low bits not a multiple of 2^me_size, or size D with XLEN=32; IDLE with mem op and misaligned -> DONE, wb_fault=1, wb_data=0, and no bus transaction.
REQ-017 SHALL: IDLE with aligned mem op -> BUSY; latch address, size, unsigned flag, direction and formatted store data.
REQ-018 SHALL: in BUSY, mem_valid=1; mem_addr, mem_req, mem_size, mem_wdata and mem_wstrb SHALL stay constant until the handshake cycle (mem_valid & mem_ready).
REQ-019 SHALL: offset = addr[log2(XLEN/8)-1:0]; mem_wdata = rs2 << 8*offset; mem_wstrb = ((1<<2^size)-1) << offset; mem_wstrb = 0 on reads.
REQ-020 SHALL: on a load handshake, wb_data = (mem_rdata >> 8*offset) truncated to size, then sign- or zero-extended to XLEN; on a store handshake, wb_data = 0.
REQ-021 SHALL: handshake -> DONE; wb_fault = (mem_resp != 0); with a fault, wb_data = 0.
REQ-022 SHALL: BUSY wait counter starts at 0 on entry and increments each cycle without mem_ready; with TIMEOUT != 0, reaching TIMEOUT forces DONE with wb_fault=1 and deasserts mem_valid.
REQ-023 SHALL: DONE asserts wb_valid for exactly one cycle, then returns to IDLE; wb_data and wb_fault SHALL hold until the next DONE.
REQ-024 SHALL: stall_req = BUSY | (IDLE & in_valid & aligned mem op); stall_req=0 in DONE.
REQ-025 SHALL: me_mem_rena & me_mem_wena both set -> treated as a store.
REQ-026 SHALL: a handshake in the same cycle the counter reaches TIMEOUT -> handshake wins, no timeout fault.
REQ-027 SHALL: in_valid during BUSY or DONE is ignored (in_ready=0); upstream holds its inputs.

Reset
REQ-028 SHALL: reset low -> state IDLE, counter 0, mem_valid=0, wb_valid=0, wb_fault=0, wb_data=0, all latched registers 0, immediately and asynchronously.
REQ-029 SHALL: reset asserted mid-BUSY -> transaction abandoned; mem_valid drops asynchronously; no wb_valid is produced.

Verification
REQ-030 SHALL: XLEN=64, load H unsigned at addr 0x1006, mem_rdata=0xBEEF_0000_0000_0000, ready after 3 cycles -> mem_valid held 3 cycles, wb_data=0xBEEF, wb_valid one cycle.
REQ-031 SHALL: load B signed at addr 0x1003, mem_rdata byte 3 = 0x80 -> wb_data=0xFFFF_FFFF_FFFF_FF80.
REQ-032 SHALL: store W at 0x2004, rs2=0x1122_3344 -> mem_wstrb=0xF0, mem_wdata=0x1122_3344_0000_0000, mem_req=1.
REQ-033 SHALL: load D at 0x3004 -> no mem_valid, wb_fault=1 one cycle after in_valid.
REQ-034 SHALL: TIMEOUT=4, mem_ready held low -> wb_fault=1 after 4 BUSY cycles; a second run with mem_ready=1 on the 4th cycle -> no fault.
REQ-035 SHALL: reset pulsed during BUSY -> mem_valid=0 immediately, IDLE after release, the next load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Memory-stage access unit. Accepts one instruction at a time,
//                issues a single aligned bus transaction for loads/stores
//                (byte-lane formatted), checks alignment, bus errors and a
//                ready timeout, and presents a one-cycle write-back pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              me_mem_rena,
   input  logic              me_mem_wena,
   input  logic [1:0]        me_size,
   input  logic              me_unsigned,
   input  logic [XLEN-1:0]   me_alu_result,
   input  logic [XLEN-1:0]   me_new_rs2_data,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   output logic [1:0]        mem_size,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic [1:0]        mem_resp,
   output logic              wb_valid,
   output logic [XLEN-1:0]   wb_data,
   output logic              wb_fault,
   output logic              stall_req
);

   localparam int STRB_W = XLEN / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // Counter value in the last BUSY cycle before a timeout fires
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]     addr_q, addr_d;
   logic [1:0]          size_q, size_d;
   logic                unsigned_q, unsigned_d;
   logic                write_q, write_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [XLEN-1:0]     wb_data_q, wb_data_d;
   logic                wb_fault_q, wb_fault_d;

   logic                mem_op;
   logic                misaligned;
   logic [OFF_W-1:0]    in_off;
   logic [STRB_W-1:0]   strb_base;
   logic [STRB_W-1:0]   req_strb;
   logic [XLEN-1:0]     req_wdata;

   logic [OFF_W-1:0]    ld_off;
   logic [XLEN-1:0]     ld_shift;
   logic [XLEN-1:0]     ld_left;
   logic [6:0]          ld_sh;
   logic [XLEN-1:0]     ld_data;

   // Decode the incoming request: alignment, byte strobes and lane-shifted store data
   always_comb begin
      mem_op     = me_mem_rena | me_mem_wena;
      in_off     = me_alu_result[OFF_W-1:0];
      misaligned = 1'b0;
      strb_base  = '0;
      case (me_size)
         2'd0: begin
            misaligned   = 1'b0;
            strb_base[0] = 1'b1;
         end
         2'd1: begin
            misaligned     = me_alu_result[0];
            strb_base[1:0] = 2'b11;
         end
         2'd2: begin
            misaligned     = |me_alu_result[1:0];
            strb_base[3:0] = 4'hF;
         end
         default: begin
            // A doubleword cannot be carried on a 32-bit bus
            misaligned = (XLEN == 32) || (|me_alu_result[2:0]);
            strb_base  = '1;
         end
      endcase
      req_strb  = strb_base << in_off;
      req_wdata = me_new_rs2_data << {in_off, 3'b000};
   end

   // Pull the addressed lane out of the returned word and sign/zero-extend it
   always_comb begin
      ld_off   = addr_q[OFF_W-1:0];
      ld_shift = mem_rdata >> {ld_off, 3'b000};
      case (size_q)
         2'd0:    ld_sh = 7'(XLEN - 8);
         2'd1:    ld_sh = 7'(XLEN - 16);
         2'd2:    ld_sh = 7'(XLEN - 32);
         default: ld_sh = 7'd0;
      endcase
      // Move the field to the top, then shift it back down logically or arithmetically
      ld_left = ld_shift << ld_sh;
      if (unsigned_q) begin
         ld_data = ld_left >> ld_sh;
      end else begin
         ld_data = XLEN'($signed(ld_left) >>> ld_sh);
      end
   end

   // Next-state, latched-request and write-back result logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      wb_data_d  = wb_data_q;
      wb_fault_d = wb_fault_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (!mem_op) begin
                  state_d    = S_DONE;
                  wb_data_d  = me_alu_result;
                  wb_fault_d = 1'b0;
               end else if (misaligned) begin
                  state_d    = S_DONE;
                  wb_data_d  = '0;
                  wb_fault_d = 1'b1;
               end else begin
                  state_d    = S_BUSY;
                  cnt_d      = '0;
                  addr_d     = me_alu_result;
                  size_d     = me_size;
                  unsigned_d = me_unsigned;
                  // A request with both enables set is a store
                  write_d    = me_mem_wena;
                  wdata_d    = req_wdata;
                  wstrb_d    = me_mem_wena ? req_strb : '0;
               end
            end
         end
         S_BUSY: begin
            // The handshake is checked first so it wins over a coincident timeout
            if (mem_ready) begin
               state_d    = S_DONE;
               cnt_d      = '0;
               wb_fault_d = (mem_resp != 2'd0);
               wb_data_d  = ((mem_resp != 2'd0) || write_q) ? '0 : ld_data;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               state_d    = S_DONE;
               cnt_d      = '0;
               wb_fault_d = 1'b1;
               wb_data_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         size_q     <= '0;
         unsigned_q <= 1'b0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wb_data_q  <= '0;
         wb_fault_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         wb_data_q  <= wb_data_d;
         wb_fault_q <= wb_fault_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign mem_valid = (state_q == S_BUSY);
   assign mem_req   = write_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;
   assign mem_size  = size_q;
   assign wb_valid  = (state_q == S_DONE);
   assign wb_data   = wb_data_q;
   assign wb_fault  = wb_fault_q;
   assign stall_req = (state_q == S_BUSY) ||
                      ((state_q == S_IDLE) && in_valid && mem_op && !misaligned);

endmodule
`default_nettype wire
